// File: rtl/count_seq_pkg.sv
// Shared types and defaults for the count sequencer and its closed-loop wrapper.
package count_seq_pkg;

    localparam int DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/count_seq_top.sv
// Closed loop of sequencer and counter, with the count fed back to the sequencer.
module count_seq_top
    import count_seq_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [N-1:0] start_value_i,
    input  logic [N-1:0] target_value_i,
    output logic [N-1:0] count_o,
    output logic         busy_o,
    output logic         done_o
);

    logic         load;
    logic [N-1:0] load_value;
    logic         enable;
    logic         dec;

    count_sequencer #(.N(N)) u_seq (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .start_value_i  (start_value_i),
        .target_value_i (target_value_i),
        .count_i        (count_o),
        .load_o         (load),
        .load_value_o   (load_value),
        .enable_o       (enable),
        .dec_o          (dec),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    counter_nbit #(.N(N)) u_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (load),
        .load_value_i (load_value),
        .enable_i     (enable),
        .dec_i        (dec),
        .count_o      (count_o)
    );

endmodule

// File: rtl/counter_nbit.sv
// Loadable modulo-2^N up/down counter; load has priority over enable.
module counter_nbit
    import count_seq_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [N-1:0] load_value_i,
    input  logic         enable_i,
    input  logic         dec_i,
    output logic [N-1:0] count_o
);

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (enable_i) begin
            count_d = dec_i ? count_q - 1'b1 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/count_sequencer.sv
// Run controller: loads a counter with a start value and steers it toward a
// target, pulsing done on arrival; abort returns to idle without done.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [N-1:0] start_value_i,
    input  logic [N-1:0] target_value_i,
    input  logic [N-1:0] count_i,
    output logic         load_o,
    output logic [N-1:0] load_value_o,
    output logic         enable_o,
    output logic         dec_o,
    output logic         busy_o,
    output logic         done_o
);

    state_t       state_q, state_d;
    logic [N-1:0] start_q, start_d;
    logic [N-1:0] target_q, target_d;

    always_comb begin
        state_d      = state_q;
        start_d      = start_q;
        target_d     = target_q;
        load_o       = 1'b0;
        load_value_o = '0;
        enable_o     = 1'b0;
        dec_o        = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    start_d  = start_value_i;
                    target_d = target_value_i;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                busy_o = 1'b1;
                // Abort suppresses the load so the counter keeps its value.
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    load_o       = 1'b1;
                    load_value_o = start_q;
                    state_d      = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                dec_o  = (count_i > target_q);
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    enable_o = (count_i != target_q);
                    if (count_i == target_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            start_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            target_q <= target_d;
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Directed and randomized runs of count_sequencer driving a bench-side counter.
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] sv = '0;
    logic [7:0] tv = '0;
    logic [7:0] cnt;
    logic       load, en, dec, busy, done;
    logic [7:0] lv;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    count_sequencer #(.N(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .abort_i        (abort),
        .start_value_i  (sv),
        .target_value_i (tv),
        .count_i        (cnt),
        .load_o         (load),
        .load_value_o   (lv),
        .enable_o       (en),
        .dec_o          (dec),
        .busy_o         (busy),
        .done_o         (done)
    );

    // The controlled counter: load over enable, modulo 256.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= 8'd0;
        else if (load) cnt <= lv;
        else if (en)   cnt <= dec ? cnt - 8'd1 : cnt + 8'd1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_load"}, 32'(load), 0);
        chk({tag, "_lv"}, 32'(lv), 0);
        chk({tag, "_enable"}, 32'(en), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // Full run from idle: expected trace is derived from start, target and distance.
    task automatic do_run(input int s, input int t, input bit noisy);
        int d;
        d = (s > t) ? s - t : t - s;
        start = 1'b1; sv = 8'(s); tv = 8'(t);
        @(negedge clk);
        start = 1'b0;
        if (noisy) begin sv = 8'($urandom); tv = 8'd5; end
        chk("load_pulse", 32'(load), 1);
        chk("load_value", 32'(lv), 32'(s));
        chk("load_enable", 32'(en), 0);
        chk("load_busy", 32'(busy), 1);
        chk("load_done", 32'(done), 0);
        for (int k = 1; k <= d + 1; k++) begin
            @(negedge clk);
            chk("run_count", 32'(cnt), 32'((s > t) ? s - (k - 1) : s + (k - 1)));
            chk("run_enable", 32'(en), 32'(k <= d));
            chk("run_dec", 32'(dec), 32'((k <= d) && (s > t)));
            chk("run_load", 32'(load), 0);
            chk("run_lv", 32'(lv), 0);
            chk("run_busy", 32'(busy), 1);
            chk("run_done", 32'(done), 0);
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                sv = 8'($urandom);
                tv = 8'(($urandom_range(0, 1) == 1) ? 5 : $urandom);
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", 32'(done), 1);
        chk("done_enable", 32'(en), 0);
        chk("done_busy", 32'(busy), 1);
        chk("done_count", 32'(cnt), 32'(t));
        @(negedge clk);
        chk_idle("post_done");
        chk("post_count", 32'(cnt), 32'(t));
    endtask

    initial begin
        int s, t, n;
        repeat (3) @(negedge clk);
        #1;
        chk_idle("reset");
        chk("reset_dec", 32'(dec), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("idle");

        do_run(10, 14, 1'b0);
        do_run(200, 197, 1'b0);
        do_run(55, 55, 1'b0);
        do_run(0, 20, 1'b1);
        for (int i = 0; i < 10; i++) begin
            s = int'($urandom_range(0, 255));
            t = s + int'($urandom_range(0, 60)) - 30;
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            do_run(s, t, 1'b1);
        end

        // Abort mid-run at count 100 of a 0->255 run.
        start = 1'b1; sv = 8'd0; tv = 8'd255;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (cnt != 8'd100 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reach100", 32'(cnt), 100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort_next");
        repeat (3) begin
            @(negedge clk);
            chk("abort_hold", 32'(cnt == 8'd100 || cnt == 8'd101), 1);
            chk("abort_nodone", 32'(done), 0);
        end

        // Abort during LOAD.
        start = 1'b1; sv = 8'd7; tv = 8'd9;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort_load");
        @(negedge clk);
        chk_idle("abort_load2");

        // Abort in the very cycle the target is reached.
        start = 1'b1; sv = 8'd30; tv = 8'd32;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (cnt != 8'd32 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("abort_tgt_reach", 32'(cnt), 32);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort_tgt");
        @(negedge clk);
        chk_idle("abort_tgt2");

        // Reset asserted mid-run, then an immediate new run.
        start = 1'b1; sv = 8'd0; tv = 8'd50;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_idle("async_reset");
        chk("async_reset_dec", 32'(dec), 0);
        @(negedge clk);
        chk_idle("held_reset");
        rst_n = 1'b1;
        do_run(3, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
